serial_word_loader: RTL
=======================

Name: serial_word_loader

Overview:
Upstream feeder for the 3-bit load-select register. It deframes a slow serial bit stream into WIDTH-bit words. Serial bits arrive qualified by a bit-rate strobe. For each good frame it presents the word on data and pulses select for one clock, so the downstream register captures exactly one new value per frame and holds it otherwise. Bad frames are dropped and counted.

Parameters:
WIDTH, 3, payload bits per frame; matches the downstream register width.
PARITY_EN, 1, 1 = frame carries a parity bit after the payload; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity over payload plus parity bit; 1 = odd parity.

Ports:
clk  input  1  system clock, all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
serial_in  input  1  serial line; idle level 1.
bit_en  input  1  one-clock strobe; serial_in is sampled only in cycles where bit_en=1.
data  output  WIDTH  last good word, LSB = first payload bit received.
select  output  1  one-clock load pulse to downstream; data is valid while select=1.
busy  output  1  1 while a frame is in progress (state != IDLE).
frame_err  output  1  one-clock pulse: stop bit sampled as 0.
parity_err  output  1  one-clock pulse: parity mismatch (PARITY_EN=1 only).
err_cnt  output  8  saturating count of dropped frames.

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE; data=0; select=0; busy=0; frame_err=0; parity_err=0; err_cnt=0; shift register and bit counter cleared. Reset takes priority over all other inputs.
- Reset mid-frame: the partial frame is discarded, no pulse on select or the error outputs, and err_cnt is not incremented (it is cleared).
- All outputs are registered. No path from serial_in to any output is combinational.
- When bit_en=0, state and the shift register hold. Single-cycle pulse outputs still self-clear.
- FSM, advancing only on bit_en=1:
  - IDLE: serial_in=0 -> START_SEEN → DATA with bit count 0; serial_in=1 → stay in IDLE.
  - DATA: shift serial_in into bit position [count], LSB first. After WIDTH bits, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: sample the stop bit, evaluate the frame, return to IDLE.
- A new start bit is accepted on the next bit_en after STOP. There is no dead cycle requirement.
- Evaluation at the STOP sample (cycle t), with results visible in cycle t+1:
  - Good frame (stop=1 and parity ok, or PARITY_EN=0): data ← shift register; select=1 for exactly one cycle (t+1).
  - stop=0: frame_err=1 for one cycle; data unchanged; select stays 0; err_cnt+1.
  - Parity mismatch with stop=1: parity_err=1 for one cycle; data unchanged; err_cnt+1.
  - stop=0 and parity mismatch together: both error pulses assert; err_cnt increments by 1 only.
- Parity check: even mode passes when XOR(payload, parity bit)=0; odd mode passes when it equals 1.
- err_cnt saturates at 255; it never wraps.
- data is held between select pulses, so the downstream register sees a stable value even when its own select is glitch-free only.
- busy=1 from the cycle after the start bit is sampled until the cycle after the stop bit is sampled.
- Latency: select rises exactly 1 clk after the bit_en cycle that samples the stop bit.
- A start bit followed by bits while bit_en is held continuously high is legal (bit_en every cycle = max rate).

Test Plan:
- Reset: assert reset for 2 cycles while serial_in toggles → data=0, select=0, busy=0, err_cnt=0.
- Good frame, even parity, bit_en every 4 clks: send 0,1,0,1,0,1 (start, payload 101, parity 0, stop) → data=3'b101, select high exactly 1 clk, 1 clk after the stop-sample edge; no error pulses.
- Parity error: send start, payload 110, parity 1, stop 1 → parity_err pulse; select stays 0; data keeps its previous value 3'b101; err_cnt=1.
- Framing error with both errors: payload 011, bad parity, stop=0 → frame_err and parity_err pulse together; err_cnt increments by exactly 1.
- Reset mid-frame: assert reset after 2 payload bits, then send a full good frame of 3'b010 → no select during the aborted frame; a single select with data=3'b010 afterwards.
- Back-to-back frames and saturation: bit_en held high, 2 consecutive good frames (3'b111, 3'b001) → 2 select pulses, data updates in order. Then 260 framing-error frames → err_cnt=255.

Source files
------------

// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
//
// Purpose:
//   Deframes a slow, strobe-qualified serial bit stream into WIDTH-bit words
//   for the downstream load-select register. Each frame is a start bit (0),
//   WIDTH payload bits sent LSB first, an optional parity bit and a stop bit
//   (1). For every good frame the word is placed on data and select pulses
//   for one clock. Bad frames are dropped, flagged and counted.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   synchronous active-high reset, highest priority
//   serial_in  in   serial line, idle level 1
//   bit_en     in   one-clock strobe; serial_in is sampled only when 1
//   data       out  WIDTH  last good word (LSB = first payload bit)
//   select     out  one-clock load pulse; data is valid while it is high
//   busy       out  1 while a frame is in progress
//   frame_err  out  one-clock pulse: stop bit sampled as 0
//   parity_err out  one-clock pulse: parity mismatch
//   err_cnt    out  8  saturating count of dropped frames
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module serial_word_loader #(
    parameter int WIDTH      = 3,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data,
    output logic             select,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic [7:0]       err_cnt
);

    // Bit counter only needs to index the payload bits.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic         PAR_EN    = (PARITY_EN != 0);
    localparam logic         PAR_ODD   = (PARITY_ODD != 0);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [7:0]   CNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             parity_bit_reg;
    logic [WIDTH-1:0] data_reg;
    logic             select_reg;
    logic             busy_reg;
    logic             frame_err_reg;
    logic             parity_err_reg;
    logic [7:0]       err_cnt_reg;

    logic [WIDTH-1:0] shift_next;
    logic             payload_xor;
    logic             parity_ok;

    // Payload bits land at the position given by the bit counter rather than
    // being shifted, so the first bit received ends up as the LSB directly.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            assign shift_next[gi] = (count_reg == CW'(gi)) ? serial_in
                                                          : shift_reg[gi];
        end
    endgenerate

    // Even mode passes when payload XOR parity bit is 0, odd mode when it is 1.
    // Without a parity bit every frame passes this check.
    assign payload_xor = ^shift_reg;
    assign parity_ok   = !PAR_EN || ((payload_xor ^ parity_bit_reg) == PAR_ODD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            shift_reg      <= '0;
            parity_bit_reg <= 1'b0;
            data_reg       <= '0;
            select_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            // Pulse outputs self-clear every cycle, strobe or not.
            select_reg     <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;

            if (bit_en) begin
                case (state_reg)
                    IDLE: begin
                        if (!serial_in) begin
                            state_reg      <= DATA;
                            count_reg      <= '0;
                            shift_reg      <= '0;
                            parity_bit_reg <= 1'b0;
                            busy_reg       <= 1'b1;
                        end
                    end

                    DATA: begin
                        shift_reg <= shift_next;
                        if (count_reg == LAST_BIT) begin
                            count_reg <= '0;
                            state_reg <= PAR_EN ? PARITY : STOP;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end

                    PARITY: begin
                        parity_bit_reg <= serial_in;
                        state_reg      <= STOP;
                    end

                    STOP: begin
                        // serial_in is the stop bit; the frame is judged now
                        // and the result appears on the outputs next cycle.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (serial_in && parity_ok) begin
                            data_reg   <= shift_reg;
                            select_reg <= 1'b1;
                        end else begin
                            frame_err_reg  <= !serial_in;
                            parity_err_reg <= !parity_ok;
                            // One increment per dropped frame, even when both
                            // error kinds hit the same frame.
                            if (err_cnt_reg != CNT_MAX) begin
                                err_cnt_reg <= err_cnt_reg + 8'd1;
                            end
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data       = data_reg;
    assign select     = select_reg;
    assign busy       = busy_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign err_cnt    = err_cnt_reg;

endmodule
